// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- definitions shared by the instruction-memory loader and
// the instruction memory itself.
//   IMEM_WORDS     : instruction memory depth in 32-bit words
//   loader_state_t : loader FSM states
//   is_loading     : states in which the loader accepts stream bytes
package imem_loader_pkg;

  localparam int IMEM_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic is_loading(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer -- assembles little-endian 32-bit words from a byte stream.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart assembly at byte 0 of a word
//   push      : a data byte is accepted this cycle
//   din       : the accepted byte
//   word      : assembled word, valid while word_done is high
//   word_done : this push carries the 4th (most significant) byte
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);

  // Only the first three bytes are stored; the fourth is taken straight
  // from din so the word is ready on the same cycle it completes.
  logic [23:0] sreg;
  logic [1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (push) begin
      sreg <= {din, sreg[23:8]};
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_done = push && (cnt == 2'd3);
  assign word      = {din, sreg};

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads instruction memory from a byte stream while holding
// the core in reset.
// Stream: N (16-bit LE), N words (4 bytes LE each), then, when the
// IMEM_LOADER_CSUM_EN macro is defined, one XOR checksum byte over the data
// bytes. Without the macro the load completes after the last word.
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   Load_Start            : start a load (honoured in IDLE or ERROR only)
//   Byte_Valid/Byte_Data  : offered stream byte
//   Byte_Ready            : byte accepted when Byte_Valid is also high
//   Mem_WE/Mem_Addr/Mem_WData : instruction memory write port
//   Core_Hold             : core held in reset / fetch disabled
//   Load_Done             : one-cycle pulse on successful completion
//   Load_Err              : high in ERROR until the next Load_Start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = IMEM_WORDS,
  parameter int TIMEOUT   = 65535
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Load_Start,
  input  logic                         Byte_Valid,
  input  logic [7:0]                   Byte_Data,
  output logic                         Byte_Ready,
  output logic                         Mem_WE,
  output logic [$clog2(MEM_WORDS)-1:0] Mem_Addr,
  output logic [31:0]                  Mem_WData,
  output logic                         Core_Hold,
  output logic                         Load_Done,
  output logic                         Load_Err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t state, state_nxt;

  logic [AW-1:0] idx;
  logic [15:0]   len;
  logic [15:0]   len_rx;
  logic [TW-1:0] idle_cnt;
  logic          xfer, start, data_push, len_bad, last_word, timed_out;
  logic [31:0]   word;
  logic          word_done;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum;
`endif

  // xfer is derived from state directly (not from Byte_Ready) to keep the
  // output decode and next-state logic free of a combinational loop.
  assign xfer      = Byte_Valid && is_loading(state);
  assign start     = Load_Start && ((state == IDLE) || (state == ERROR));
  assign data_push = xfer && (state == DATA);
  assign len_rx    = {Byte_Data, len[7:0]};
  assign len_bad   = (len_rx == 16'd0) || (32'(len_rx) > 32'(MEM_WORDS));
  assign last_word = (16'(idx) == len - 16'd1);
  // TIMEOUT-th consecutive idle cycle in a loading state
  assign timed_out = is_loading(state) && !xfer &&
                     (idle_cnt == TW'(TIMEOUT - 1));

  byte_packer u_packer (
    .clk       (CLK),
    .rst       (RST),
    .clr       (start),
    .push      (data_push),
    .din       (Byte_Data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Byte_Ready = 1'b0;
    Core_Hold  = 1'b0;
    Load_Done  = 1'b0;
    Load_Err   = 1'b0;

    unique case (state)
      IDLE, ERROR: if (start) state_nxt = LEN_LO;
      LEN_LO:      if (xfer) state_nxt = LEN_HI;
      LEN_HI:      if (xfer) state_nxt = len_bad ? ERROR : DATA;
      DATA: begin
        // Leave DATA on the last byte itself so the next cycle can already
        // take the following byte; the write lands in that next cycle.
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        if (xfer) state_nxt = (Byte_Data == csum) ? DONE : ERROR;
`else
        state_nxt = ERROR;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (timed_out) state_nxt = ERROR;

    Byte_Ready = is_loading(state);
    Core_Hold  = (state != IDLE);
    Load_Done  = (state == DONE);
    Load_Err   = (state == ERROR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx       <= '0;
      len       <= '0;
      idle_cnt  <= '0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
    end else begin
      Mem_WE <= 1'b0;
      if (start) begin
        idx      <= '0;
        idle_cnt <= '0;
      end else begin
        if (xfer)                    idle_cnt <= '0;
        else if (is_loading(state))  idle_cnt <= idle_cnt + TW'(1);

        if (xfer && (state == LEN_LO)) len[7:0]  <= Byte_Data;
        if (xfer && (state == LEN_HI)) len[15:8] <= Byte_Data;

        // idx stays below N <= MEM_WORDS while writes are possible
        if (word_done) begin
          Mem_WE    <= 1'b1;
          Mem_Addr  <= idx;
          Mem_WData <= word;
          idx       <= idx + AW'(1);
        end
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            csum <= '0;
    else if (start)     csum <= '0;
    else if (data_push) csum <= csum ^ Byte_Data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- randomized self-checking bench for imem_loader.
// A byte-position reference model predicts every output each cycle; a few
// directed loads pin literal results.
module tb_imem_loader;

  localparam int MW = 256;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Load_Start, Byte_Valid;
  logic [7:0]  Byte_Data;
  logic        Byte_Ready, Mem_WE, Core_Hold, Load_Done, Load_Err;
  logic [7:0]  Mem_Addr;
  logic [31:0] Mem_WData;

  imem_loader #(.MEM_WORDS(MW), .TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Load_Start (Load_Start),
    .Byte_Valid (Byte_Valid),
    .Byte_Data  (Byte_Data),
    .Byte_Ready (Byte_Ready),
    .Mem_WE     (Mem_WE),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Core_Hold  (Core_Hold),
    .Load_Done  (Load_Done),
    .Load_Err   (Load_Err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stream position based) ----------------
  bit          m_init = 0;
  bit          m_active, m_err, m_done, m_we;
  int          m_k, m_n, m_idle, m_di, m_addr;
  logic [7:0]  m_csum;
  logic [31:0] m_acc, m_wdata;

  initial begin : model
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_active = 0; m_err = 0; m_done = 0; m_we = 0;
        m_k = 0; m_idle = 0; m_csum = 0; m_init = 1;
      end else begin
        m_we = 0;
        if (m_done) m_done = 0;
        else if (!m_active) begin
          if (Load_Start) begin
            m_active = 1; m_err = 0; m_k = 0; m_idle = 0; m_csum = 0;
          end
        end else if (Byte_Valid) begin
          m_idle = 0;
          if (m_k == 0) m_n = int'(Byte_Data);
          else if (m_k == 1) begin
            m_n = m_n + int'(Byte_Data) * 256;
            if (m_n == 0 || m_n > MW) begin m_active = 0; m_err = 1; end
          end else if (m_k < 2 + 4 * m_n) begin
            m_di   = m_k - 2;
            m_csum = m_csum ^ Byte_Data;
            m_acc  = (m_di % 4 == 0) ? 32'(Byte_Data)
                                     : (m_acc | (32'(Byte_Data) << (8 * (m_di % 4))));
            if (m_di % 4 == 3) begin
              m_we = 1; m_addr = m_di / 4; m_wdata = m_acc;
              if (m_di == 4 * m_n - 1) begin
`ifndef IMEM_LOADER_CSUM_EN
                m_active = 0; m_done = 1;
`endif
              end
            end
          end else begin
            m_active = 0;
            if (Byte_Data == m_csum) m_done = 1;
            else m_err = 1;
          end
          m_k++;
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_active = 0; m_err = 1; end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          dut_writes = 0, dut_dones = 0;
  logic [7:0]  last_addr;
  logic [31:0] last_data;

  initial begin : compare
    forever begin
      @(negedge CLK);
      if (m_init) begin
        check("byte_ready", 32'(Byte_Ready), 32'(m_active));
        check("core_hold",  32'(Core_Hold),  32'(m_active | m_done | m_err));
        check("load_done",  32'(Load_Done),  32'(m_done));
        check("load_err",   32'(Load_Err),   32'(m_err));
        check("mem_we",     32'(Mem_WE),     32'(m_we));
        if (m_we) begin
          check("mem_addr",  32'(Mem_Addr), 32'(m_addr));
          check("mem_wdata", Mem_WData,     m_wdata);
        end
        if (Mem_WE) begin dut_writes++; last_addr = Mem_Addr; last_data = Mem_WData; end
        if (Load_Done) dut_dones++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] stream[$];

  task automatic clr_counts();
    dut_writes = 0; dut_dones = 0;
  endtask

  task automatic start_load();
    @(negedge CLK); Load_Start = 1'b1;
    @(negedge CLK); Load_Start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic send_stream(input int gap_pct, input bit rnd_start, output bit ok, output int cyc);
    int budget;
    budget = 4 * stream.size() + 50;
    ok = 1'b1; cyc = 0;
    while (stream.size() > 0) begin
      @(negedge CLK);
      cyc++;
      Byte_Valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
      Byte_Data  = Byte_Valid ? stream[0] : 8'($urandom);
      Load_Start = rnd_start && ($urandom_range(0, 31) == 0);
      if (Byte_Valid && Byte_Ready) void'(stream.pop_front());
      if (--budget == 0) begin ok = 1'b0; break; end
    end
    @(negedge CLK);
    Byte_Valid = 1'b0; Load_Start = 1'b0;
  endtask

  // length bytes, n random data words when n is legal, then checksum
  task automatic build(input int n, input bit corrupt);
    logic [7:0] cs, b;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    cs = 8'h00;
    if (n >= 1 && n <= MW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        cs = cs ^ b;
        stream.push_back(b);
      end
`ifdef IMEM_LOADER_CSUM_EN
      stream.push_back(corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs);
`endif
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    bit ok;
    int cyc, n;
    bit corrupt;
    RST = 1'b1; Load_Start = 1'b0; Byte_Valid = 1'b0; Byte_Data = 8'h00;
    wait_cyc(3);
    check("rst_ready", 32'(Byte_Ready), 0);
    check("rst_we",    32'(Mem_WE), 0);
    check("rst_addr",  32'(Mem_Addr), 0);
    check("rst_wdata", Mem_WData, 0);
    check("rst_hold",  32'(Core_Hold), 0);
    check("rst_done",  32'(Load_Done), 0);
    check("rst_err",   32'(Load_Err), 0);
    RST = 1'b0;

    // single word 0x00000013
    clr_counts();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
    stream.push_back(8'h13);
`endif
    start_load();
    send_stream(0, 0, ok, cyc);
    check("one_ok", 32'(ok), 1);
    wait_cyc(4);
    check("one_writes", 32'(dut_writes), 1);
    check("one_addr",   32'(last_addr), 0);
    check("one_data",   last_data, 32'h0000_0013);
    check("one_dones",  32'(dut_dones), 1);
    check("one_hold",   32'(Core_Hold), 0);

    // N=2 back-to-back, no stall
    clr_counts();
    build(2, 0);
    n = stream.size();
    start_load();
    send_stream(0, 0, ok, cyc);
    check("two_ok", 32'(ok), 1);
    check("two_nostall_cycles", 32'(cyc), 32'(n));
    wait_cyc(4);
    check("two_writes", 32'(dut_writes), 2);
    check("two_last_addr", 32'(last_addr), 1);
    check("two_dones", 32'(dut_dones), 1);

    // asynchronous reset after 2 of 4 data bytes
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    start_load();
    send_stream(0, 0, ok, cyc);
    #2 RST = 1'b1;
    #1;
    check("arst_ready", 32'(Byte_Ready), 0);
    check("arst_we",    32'(Mem_WE), 0);
    check("arst_addr",  32'(Mem_Addr), 0);
    check("arst_wdata", Mem_WData, 0);
    check("arst_hold",  32'(Core_Hold), 0);
    check("arst_done",  32'(Load_Done), 0);
    check("arst_err",   32'(Load_Err), 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    clr_counts();
    @(negedge CLK); Byte_Valid = 1'b1; Byte_Data = 8'hCC;
    @(negedge CLK); Byte_Data = 8'hDD;
    @(negedge CLK); Byte_Valid = 1'b0;
    wait_cyc(3);
    check("arst_no_write", 32'(dut_writes), 0);
    check("arst_idle_hold", 32'(Core_Hold), 0);

    // illegal lengths: 0 and MW+1
    clr_counts();
    stream = '{8'h00, 8'h00};
    start_load();
    send_stream(0, 0, ok, cyc);
    wait_cyc(3);
    check("len0_err", 32'(Load_Err), 1);
    check("len0_ready", 32'(Byte_Ready), 0);
    stream = '{8'h01, 8'h01};
    start_load();
    send_stream(0, 0, ok, cyc);
    wait_cyc(3);
    check("len257_err", 32'(Load_Err), 1);
    check("badlen_writes", 32'(dut_writes), 0);

`ifdef IMEM_LOADER_CSUM_EN
    // checksum mismatch, then restart clears the error
    clr_counts();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
    start_load();
    send_stream(0, 0, ok, cyc);
    wait_cyc(3);
    check("csum_writes", 32'(dut_writes), 1);
    check("csum_err",  32'(Load_Err), 1);
    check("csum_hold", 32'(Core_Hold), 1);
    start_load();
    #1;
    check("csum_restart_err", 32'(Load_Err), 0);
    check("csum_restart_hold", 32'(Core_Hold), 1);
`endif

    // timeout mid-word
    clr_counts();
    stream = '{8'h02, 8'h00, 8'h11, 8'h22};
    start_load();
    send_stream(0, 0, ok, cyc);
    wait_cyc(TO + 4);
    check("to_err", 32'(Load_Err), 1);
    check("to_writes", 32'(dut_writes), 0);

    // randomized loads with gaps and stray Load_Start pulses
    for (int it = 0; it < 14; it++) begin
      n = (it == 3) ? MW : (it == 6) ? MW + 1 : (it == 9) ? 0 : $urandom_range(1, 6);
      corrupt = ($urandom_range(0, 3) == 0);
      clr_counts();
      build(n, corrupt);
      start_load();
      send_stream(25, 1, ok, cyc);
      check("rnd_ok", 32'(ok), 1);
      wait_cyc(4);
      if (n >= 1 && n <= MW) begin
        check("rnd_writes", 32'(dut_writes), 32'(n));
`ifdef IMEM_LOADER_CSUM_EN
        check("rnd_err", 32'(Load_Err), 32'(corrupt));
`else
        check("rnd_err", 32'(Load_Err), 0);
`endif
      end else begin
        check("rnd_badlen_err", 32'(Load_Err), 1);
        check("rnd_badlen_writes", 32'(dut_writes), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
